// File: rtl/dram_pattern_checker_if.sv
// Request/response bus between the pattern checker (master) and the cache CPU-side port (slave).
interface dram_pattern_checker_if #(
  parameter int ADDR_W = 27,
  parameter int DATA_W = 32
) ();
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              req_rw;
  logic              req_valid;
  logic [DATA_W-1:0] res_data;
  logic              res_ready;

  modport master (
    output req_addr, req_data, req_rw, req_valid,
    input  res_data, res_ready
  );

  modport slave (
    input  req_addr, req_data, req_rw, req_valid,
    output res_data, res_ready
  );
endinterface

// File: rtl/dram_pattern_checker.sv
// Write-then-read-back memory pattern checker with pass/fail, error count and first failing address.
// Optional per-request watchdog enabled by defining DRAM_CHK_TIMEOUT_EN.
module dram_pattern_checker #(
  parameter int                ADDR_W      = 27,
  parameter int                DATA_W      = 32,
  parameter int                NUM_WORDS   = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                ADDR_STRIDE = 4,
  parameter logic [31:0]       SEED        = 32'h33333333,
  parameter int                ERR_CNT_W   = 8,
  parameter int                TIMEOUT_CYC = 4096
) (
  input  logic                 sys_clk,
  input  logic                 RST,
  input  logic                 start,
  input  logic [1:0]           mode,
  dram_pattern_checker_if.master bus,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [ADDR_W-1:0]    first_err_addr,
  output logic                 timeout,
  output logic                 led_memory
);

  // state    | meaning
  // IDLE     | after reset, waiting for start
  // WR_ISSUE | write request on the bus (req_valid high)
  // WR_WAIT  | waiting for write completion
  // RD_ISSUE | read request on the bus (req_valid high)
  // RD_WAIT  | waiting for read data, compare on res_ready
  // DONE     | results held until the next start
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR_ISSUE = 3'd1,
    S_WR_WAIT  = 3'd2,
    S_RD_ISSUE = 3'd3,
    S_RD_WAIT  = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  localparam int          IDX_W     = $clog2(NUM_WORDS + 1);
  localparam logic [31:0] LFSR_POLY = 32'h80200003;

  state_t               state_q, state_d;
  logic [1:0]           mode_q, mode_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [ADDR_W-1:0]    gen_addr_q, gen_addr_d;
  logic [DATA_W-1:0]    walk_q, walk_d;
  logic [31:0]          lfsr_q, lfsr_d;
  logic [ADDR_W-1:0]    req_addr_q, req_addr_d;
  logic [DATA_W-1:0]    req_data_q, req_data_d;
  logic                 req_rw_q, req_rw_d;
  logic                 req_valid_q, req_valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic                 led_q, led_d;
  logic                 timeout_q, timeout_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0]    first_err_q, first_err_d;

  logic                 issue, issue_rw, restart_gen, finish;
  logic [ADDR_W-1:0]    src_addr;
  logic [DATA_W-1:0]    src_walk;
  logic [31:0]          src_lfsr;
  logic [IDX_W-1:0]     src_idx;
  logic                 last_word;

`ifdef DRAM_CHK_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             tmo_hit;
  assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
`endif

  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    lfsr_step = l[0] ? ((l >> 1) ^ LFSR_POLY) : (l >> 1);
  endfunction

  function automatic logic [DATA_W-1:0] pattern(input logic [1:0] m, input logic [ADDR_W-1:0] a,
                                                input logic [DATA_W-1:0] w, input logic [31:0] l);
    case (m)
      2'd0:    pattern = DATA_W'(SEED);
      2'd1:    pattern = DATA_W'(a);
      2'd2:    pattern = w;
      default: pattern = DATA_W'(l);
    endcase
  endfunction

  assign last_word = (idx_q == IDX_W'(NUM_WORDS));

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    idx_d       = idx_q;
    gen_addr_d  = gen_addr_q;
    walk_d      = walk_q;
    lfsr_d      = lfsr_q;
    req_addr_d  = req_addr_q;
    req_data_d  = req_data_q;
    req_rw_d    = req_rw_q;
    req_valid_d = 1'b0;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    led_d       = led_q;
    timeout_d   = timeout_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    issue       = 1'b0;
    issue_rw    = 1'b0;
    restart_gen = 1'b0;
    finish      = 1'b0;
    src_addr    = gen_addr_q;
    src_walk    = walk_q;
    src_lfsr    = lfsr_q;
    src_idx     = idx_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          mode_d      = mode;
          err_cnt_d   = '0;
          first_err_d = '0;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          led_d       = 1'b0;
          timeout_d   = 1'b0;
          busy_d      = 1'b1;
          issue       = 1'b1;
          issue_rw    = 1'b1;
          restart_gen = 1'b1;
          state_d     = S_WR_ISSUE;
        end
      end
      S_WR_ISSUE: state_d = S_WR_WAIT;
      S_WR_WAIT: begin
        if (bus.res_ready) begin
          issue = 1'b1;
          if (last_word) begin
            restart_gen = 1'b1;
            state_d     = S_RD_ISSUE;
          end else begin
            issue_rw = 1'b1;
            state_d  = S_WR_ISSUE;
          end
        end
`ifdef DRAM_CHK_TIMEOUT_EN
        else if (tmo_hit) begin
          timeout_d = 1'b1;
          finish    = 1'b1;
        end
`endif
      end
      S_RD_ISSUE: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        if (bus.res_ready) begin
          if (bus.res_data != req_data_q) begin
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
            if (err_cnt_q == '0) first_err_d = req_addr_q;
          end
          if (last_word) begin
            finish = 1'b1;
          end else begin
            issue   = 1'b1;
            state_d = S_RD_ISSUE;
          end
        end
`ifdef DRAM_CHK_TIMEOUT_EN
        else if (tmo_hit) begin
          timeout_d = 1'b1;
          finish    = 1'b1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase

    // Generator registers always describe the next word to issue; a phase restart rewinds them.
    if (issue) begin
      if (restart_gen) begin
        src_addr = BASE_ADDR;
        src_walk = DATA_W'(1);
        src_lfsr = SEED;
        src_idx  = '0;
      end
      req_addr_d  = src_addr;
      req_data_d  = pattern(mode_d, src_addr, src_walk, src_lfsr);
      req_rw_d    = issue_rw;
      req_valid_d = 1'b1;
      gen_addr_d  = src_addr + ADDR_W'(ADDR_STRIDE);
      walk_d      = {src_walk[DATA_W-2:0], src_walk[DATA_W-1]};
      lfsr_d      = lfsr_step(src_lfsr);
      idx_d       = src_idx + IDX_W'(1);
    end

    if (finish) begin
      state_d = S_DONE;
      busy_d  = 1'b0;
      done_d  = 1'b1;
      pass_d  = (err_cnt_d == '0) & ~timeout_d;
      led_d   = (err_cnt_d == '0) & ~timeout_d;
    end
  end

`ifdef DRAM_CHK_TIMEOUT_EN
  always_comb begin
    tmo_d = tmo_q;
    if (state_q == S_WR_WAIT || state_q == S_RD_WAIT) tmo_d = tmo_q + TMO_W'(1);
    if (issue) tmo_d = '0;
  end

  always_ff @(posedge sys_clk or posedge RST) begin
    if (RST) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end
`endif

  always_ff @(posedge sys_clk or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      mode_q      <= 2'd0;
      idx_q       <= '0;
      gen_addr_q  <= BASE_ADDR;
      walk_q      <= DATA_W'(1);
      lfsr_q      <= SEED;
      req_addr_q  <= '0;
      req_data_q  <= '0;
      req_rw_q    <= 1'b0;
      req_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      led_q       <= 1'b0;
      timeout_q   <= 1'b0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      idx_q       <= idx_d;
      gen_addr_q  <= gen_addr_d;
      walk_q      <= walk_d;
      lfsr_q      <= lfsr_d;
      req_addr_q  <= req_addr_d;
      req_data_q  <= req_data_d;
      req_rw_q    <= req_rw_d;
      req_valid_q <= req_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      led_q       <= led_d;
      timeout_q   <= timeout_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
    end
  end

  assign bus.req_addr   = req_addr_q;
  assign bus.req_data   = req_data_q;
  assign bus.req_rw     = req_rw_q;
  assign bus.req_valid  = req_valid_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign led_memory     = led_q;
  assign err_count      = err_cnt_q;
  assign first_err_addr = first_err_q;
  assign timeout        = timeout_q;

endmodule

// File: tb/tb_dram_pattern_checker.sv
// Randomized bench for dram_pattern_checker: echo memory responder plus a word-level reference model.
module tb_dram_pattern_checker;
  localparam int          ADDR_W = 27;
  localparam int          DATA_W = 32;
  localparam int          N      = 40;
  localparam logic [26:0] BASE   = 27'h7FFFFC0;
  localparam logic [31:0] SEED   = 32'h33333333;
  localparam logic [31:0] POLY   = 32'h80200003;

  logic        sys_clk = 1'b0;
  logic        RST;
  logic        start;
  logic [1:0]  mode;
  logic        busy, done, pass, timeout, led_memory;
  logic [7:0]  err_count;
  logic [26:0] first_err_addr;

  dram_pattern_checker_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dram_pattern_checker #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_WORDS(N), .BASE_ADDR(BASE),
    .ADDR_STRIDE(4), .SEED(SEED), .ERR_CNT_W(8), .TIMEOUT_CYC(16)
  ) dut (
    .sys_clk(sys_clk), .RST(RST), .start(start), .mode(mode), .bus(bus),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_addr(first_err_addr), .timeout(timeout), .led_memory(led_memory)
  );

  always #5 sys_clk = ~sys_clk;

  int tests = 0;
  int fails = 0;
  int cur_mode, req_idx, nval, nrdy, nreq_run, lat_min, lat_max, drop_at;
  bit outstanding;
  logic [63:0] corrupt_mask;
  logic [31:0] mem [logic [26:0]];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [26:0] m_addr(input int i);
    logic [26:0] a;
    a = BASE + 27'(i * 4);
    return a;
  endfunction

  function automatic logic [31:0] m_data(input int m, input int i);
    logic [31:0] l;
    case (m)
      0: return SEED;
      1: return 32'(m_addr(i));
      2: return 32'd1 << (i % 32);
      default: begin
        l = SEED;
        for (int k = 0; k < i; k++) l = l[0] ? ((l >> 1) ^ POLY) : (l >> 1);
        return l;
      end
    endcase
  endfunction

  // ---------------- memory responder ----------------
  initial begin
    logic [26:0] a;
    logic [31:0] d;
    logic        w;
    int          lat, widx;
    bit          abort;
    bus.res_ready = 1'b0;
    bus.res_data  = '0;
    forever begin
      @(negedge sys_clk);
      if (!RST && bus.req_valid) begin
        a = bus.req_addr; d = bus.req_data; w = bus.req_rw;
        nreq_run++;
        if (drop_at != 0 && nreq_run == drop_at) continue;
        widx = int'((a - BASE) >> 2);
        if (w) mem[a] = (widx < 64 && corrupt_mask[widx]) ? (d ^ 32'd1) : d;
        lat = $urandom_range(lat_max, lat_min);
        @(posedge sys_clk);
        abort = RST;
        for (int k = 0; k < lat && !abort; k++) begin
          @(posedge sys_clk);
          if (RST) abort = 1'b1;
        end
        if (!abort) begin
          #1;
          if (!RST) begin
            bus.res_data  = w ? $urandom : (mem.exists(a) ? mem[a] : 32'd0);
            bus.res_ready = 1'b1;
            nrdy++;
            outstanding = 1'b0;
            @(posedge sys_clk);
            #1 bus.res_ready = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    int wi;
    forever begin
      @(negedge sys_clk);
      if (!RST) begin
        chk("led_eq_done_pass", led_memory, done & pass);
        chk("busy_done_excl", busy & done, 1'b0);
        if (bus.req_valid) begin
          chk("no_req_while_waiting", outstanding, 1'b0);
          outstanding = 1'b1;
          nval++;
          if (req_idx >= 2 * N) begin
            chk("extra_request", req_idx, 2 * N - 1);
          end else begin
            wi = (req_idx < N) ? req_idx : req_idx - N;
            chk("req_rw", bus.req_rw, req_idx < N);
            chk("req_addr", bus.req_addr, m_addr(wi));
            if (req_idx < N) chk("req_wdata", bus.req_data, m_data(cur_mode, wi));
          end
          req_idx++;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic pulse_start(input int m);
    req_idx = 0; nval = 0; nrdy = 0; nreq_run = 0; outstanding = 1'b0;
    cur_mode = m;
    mode  = 2'(m);
    start = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int extra_at, output int cycles);
    cycles = 1;
    while (!done && cycles < 20000) begin
      if (cycles == extra_at) begin start = 1'b1; mode = 2'd0; end
      @(posedge sys_clk); #1;
      start = 1'b0;
      cycles++;
    end
    if (!done) chk("run_completes", done, 1'b1);
  endtask

  task automatic check_done(input string tag, input int exp_err, input logic [26:0] exp_first, input bit exp_pass);
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_pass"}, pass, exp_pass);
    chk({tag, "_led"}, led_memory, exp_pass);
    chk({tag, "_err_count"}, err_count, exp_err);
    chk({tag, "_first_err"}, first_err_addr, exp_first);
    chk({tag, "_timeout"}, timeout, 1'b0);
    chk({tag, "_nval"}, nval, 2 * N);
    chk({tag, "_nrdy"}, nrdy, 2 * N);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_pass_led"}, {pass, led_memory, timeout}, 3'b000);
    chk({tag, "_err"}, {err_count, first_err_addr}, '0);
    chk({tag, "_req"}, {bus.req_valid, bus.req_rw, bus.req_addr, bus.req_data}, '0);
  endtask

  initial begin
    int cyc, k, seen;
    RST = 1'b1; start = 1'b0; mode = 2'd0;
    lat_min = 0; lat_max = 0; drop_at = 0; corrupt_mask = '0; outstanding = 1'b0;
    repeat (3) @(posedge sys_clk); #1;
    check_zero("reset");
    RST = 1'b0;

    // hand-computed pins of the reference model
    chk("model_lfsr_step1", m_data(3, 1), 32'h99B9999A);
    chk("model_addr_wrap", m_addr(16), 27'h0);
    chk("model_walk_wrap", m_data(2, 33), 32'h2);
    chk("model_addr_data", m_data(1, 3), 32'h07FFFFCC);

    // 1: constant pattern, zero latency
    pulse_start(0); wait_done(0, cyc);
    chk("t1_cycles", cyc, 4 * N + 1);
    check_done("t1", 0, 27'h0, 1'b1);

    // 2: walking one, rerun from DONE, address wraps past 2^27
    pulse_start(2); wait_done(0, cyc);
    chk("t2_cycles", cyc, 4 * N + 1);
    check_done("t2", 0, 27'h0, 1'b1);

    // 3: addr-as-data with words 3 and 5 corrupted
    corrupt_mask = (64'd1 << 3) | (64'd1 << 5);
    pulse_start(1); wait_done(0, cyc);
    check_done("t3", 2, m_addr(3), 1'b0);
    corrupt_mask = '0;

    // 4: LFSR, random latency, stray start mid-run must be ignored
    lat_min = 0; lat_max = 20;
    pulse_start(3); wait_done(50, cyc);
    check_done("t4", 0, 27'h0, 1'b1);

    // 5: reset in RD_WAIT of word 4, then rerun
    lat_min = 10; lat_max = 10;
    pulse_start(3);
    k = 0;
    while (req_idx < N + 5 && k < 5000) begin @(posedge sys_clk); #1; k++; end
    chk("t5_reached_rd4", req_idx, N + 5);
    repeat (2) @(posedge sys_clk); #1;
    RST = 1'b1; #1;
    check_zero("t5_rst");
    @(posedge sys_clk); #1;
    RST = 1'b0; outstanding = 1'b0;
    lat_min = 0; lat_max = 3;
    pulse_start(3); wait_done(0, cyc);
    check_done("t5", 0, 27'h0, 1'b1);

    // 6: second write never answered
    lat_min = 0; lat_max = 0; drop_at = 2;
    pulse_start(1);
    seen = bus.req_valid ? 1 : 0; k = 0;
    while (seen < 2 && k < 100) begin @(posedge sys_clk); #1; k++; if (bus.req_valid) seen++; end
    chk("t6_second_issue", seen, 2);
`ifdef DRAM_CHK_TIMEOUT_EN
    k = 0;
    while (!timeout && k < 200) begin @(posedge sys_clk); #1; k++; end
    chk("t6_timeout_latency", k, 17);
    chk("t6_flags", {timeout, done, pass, led_memory, busy}, 5'b11000);
`else
    repeat (100) @(posedge sys_clk); #1;
    chk("t6_hang_flags", {busy, done, timeout}, 3'b100);
    RST = 1'b1; @(posedge sys_clk); #1; RST = 1'b0;
`endif
    drop_at = 0;
    pulse_start(0); wait_done(0, cyc);
    check_done("t6_recover", 0, 27'h0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
